// File: rtl/ysyx_24110006_csr_ctrl.sv
// CSR execution controller: runs one CSR-class instruction at a time
// (csrrw/s/c and their immediate forms, ecall, mret) as READ -> WRITE -> RESP
// against a CSR file that has a combinational read port. It returns the old
// CSR value or a redirect target through a valid/ready handshake.
module ysyx_24110006_csr_ctrl #(
  parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_op,
  input  logic        i_imm,
  input  logic [4:0]  i_rs1,
  input  logic [31:0] i_src,
  input  logic [11:0] i_csr,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_pc,
  output logic        o_csr_valid,
  output logic        o_csr_wen,
  output logic [2:0]  o_csr_t,
  output logic [11:0] o_csr,
  output logic [31:0] o_csr_wdata,
  output logic [31:0] o_csr_pc,
  output logic [31:0] o_mcause,
  input  logic [31:0] i_csr_rdata,
  input  logic [31:0] i_csr_upc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [4:0]  o_rd,
  output logic        o_rd_wen,
  output logic [31:0] o_rd_data,
  output logic        o_jump,
  output logic [31:0] o_npc,
  output logic        o_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  localparam logic [2:0] OP_CSRRW = 3'b000;
  localparam logic [2:0] OP_CSRRS = 3'b001;
  localparam logic [2:0] OP_CSRRC = 3'b010;
  localparam logic [2:0] OP_ECALL = 3'b011;
  localparam logic [2:0] OP_MRET  = 3'b100;

  localparam logic [2:0] T_MRET  = 3'b000;
  localparam logic [2:0] T_CSRW  = 3'b001;
  localparam logic [2:0] T_READ  = 3'b010;
  localparam logic [2:0] T_ECALL = 3'b011;

  state_t state, state_nxt;

  logic [2:0]  op_q;
  logic        imm_q;
  logic [4:0]  rs1_q;
  logic [31:0] src_q;
  logic [11:0] csr_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_q;
  logic [31:0] old_q;
  logic [31:0] upc_q;
  logic [31:0] new_q;
  logic        do_write_q;
  logic        illegal_q;

  logic        is_csr_op;
  logic        is_ecall;
  logic        is_mret;
  logic [31:0] src_val;
  logic        want_write;
  logic        read_only;

  // Read-modify result for the three csr ops; other ops never write data.
  function automatic logic [31:0] csr_modify(input logic [2:0] op,
                                             input logic [31:0] old,
                                             input logic [31:0] src);
    case (op)
      OP_CSRRW: csr_modify = src;
      OP_CSRRS: csr_modify = old | src;
      OP_CSRRC: csr_modify = old & ~src;
      default:  csr_modify = 32'd0;
    endcase
  endfunction

  assign is_csr_op = (op_q <= OP_CSRRC);
  assign is_ecall  = (op_q == OP_ECALL);
  assign is_mret   = (op_q == OP_MRET);
  assign src_val   = imm_q ? {27'd0, rs1_q} : src_q;
  // csrrs/csrrc with rs1 == 0 are pure reads and must not touch the CSR.
  assign want_write = (op_q == OP_CSRRW) || is_ecall ||
                      (((op_q == OP_CSRRS) || (op_q == OP_CSRRC)) && (rs1_q != 5'd0));
  assign read_only  = (csr_q[11:10] == 2'b11);

  // State register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; RESP is left only when the response is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_valid) state_nxt = S_READ;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  if (i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture in IDLE, read/modify results captured in READ.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      op_q       <= 3'd0;
      imm_q      <= 1'b0;
      rs1_q      <= 5'd0;
      src_q      <= 32'd0;
      csr_q      <= 12'd0;
      rd_q       <= 5'd0;
      pc_q       <= 32'd0;
      old_q      <= 32'd0;
      upc_q      <= 32'd0;
      new_q      <= 32'd0;
      do_write_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && i_valid) begin
        op_q  <= i_op;
        imm_q <= i_imm;
        rs1_q <= i_rs1;
        src_q <= i_src;
        csr_q <= i_csr;
        rd_q  <= i_rd;
        pc_q  <= i_pc;
      end
      if (state == S_READ) begin
        old_q      <= i_csr_rdata;
        upc_q      <= i_csr_upc;
        new_q      <= csr_modify(op_q, i_csr_rdata, src_val);
        do_write_q <= want_write && !read_only;
        illegal_q  <= !(is_csr_op || is_ecall || is_mret) || (want_write && read_only);
      end
    end
  end

  // Output decode; the CSR strobe is masked by reset so no write lands on a reset edge.
  always_comb begin
    o_ready     = (state == S_IDLE);
    o_valid     = (state == S_RESP);
    o_csr       = csr_q;
    o_csr_wdata = new_q;
    o_csr_pc    = pc_q;
    o_mcause    = 32'd0;
    o_csr_valid = 1'b0;
    o_csr_t     = T_READ;
    if (state == S_READ) begin
      if (is_ecall)     o_csr_t = T_ECALL;
      else if (is_mret) o_csr_t = T_MRET;
    end else if (state == S_WRITE) begin
      o_csr_valid = do_write_q && i_reset;
      if (is_csr_op)    o_csr_t = T_CSRW;
      else if (is_ecall) begin
        o_csr_t  = T_ECALL;
        o_mcause = MCAUSE_ECALL;
      end else if (is_mret) o_csr_t = T_MRET;
    end
    o_csr_wen = o_csr_valid;
    o_rd      = rd_q;
    o_rd_data = is_csr_op ? old_q : 32'd0;
    o_npc     = upc_q;
    o_rd_wen  = (state == S_RESP) && is_csr_op && (rd_q != 5'd0) && !illegal_q;
    o_jump    = (state == S_RESP) && (is_ecall || is_mret);
    o_illegal = (state == S_RESP) && illegal_q;
  end

endmodule

// File: tb/tb_ysyx_24110006_csr_ctrl.sv
// Directed bench for the CSR execution controller. Inputs change and outputs
// are sampled on the falling clock edge; the CSR file read port is driven
// directly with per-step constants.
module tb_ysyx_24110006_csr_ctrl;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = 3'd0;
  logic        i_imm = 1'b0;
  logic [4:0]  i_rs1 = 5'd0;
  logic [31:0] i_src = 32'd0;
  logic [11:0] i_csr = 12'd0;
  logic [4:0]  i_rd = 5'd0;
  logic [31:0] i_pc = 32'd0;
  logic        o_csr_valid;
  logic        o_csr_wen;
  logic [2:0]  o_csr_t;
  logic [11:0] o_csr;
  logic [31:0] o_csr_wdata;
  logic [31:0] o_csr_pc;
  logic [31:0] o_mcause;
  logic [31:0] i_csr_rdata = 32'd0;
  logic [31:0] i_csr_upc = 32'd0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [4:0]  o_rd;
  logic        o_rd_wen;
  logic [31:0] o_rd_data;
  logic        o_jump;
  logic [31:0] o_npc;
  logic        o_illegal;

  int n_assert = 0;
  int n_fail   = 0;

  ysyx_24110006_csr_ctrl #(.MCAUSE_ECALL(32'd11)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_imm(i_imm), .i_rs1(i_rs1), .i_src(i_src), .i_csr(i_csr),
    .i_rd(i_rd), .i_pc(i_pc), .o_csr_valid(o_csr_valid), .o_csr_wen(o_csr_wen),
    .o_csr_t(o_csr_t), .o_csr(o_csr), .o_csr_wdata(o_csr_wdata), .o_csr_pc(o_csr_pc),
    .o_mcause(o_mcause), .i_csr_rdata(i_csr_rdata), .i_csr_upc(i_csr_upc),
    .o_valid(o_valid), .i_ready(i_ready), .o_rd(o_rd), .o_rd_wen(o_rd_wen),
    .o_rd_data(o_rd_data), .o_jump(o_jump), .o_npc(o_npc), .o_illegal(o_illegal)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs that must hold their reset values.
  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ready"}, 32'(o_ready), 32'd1);
    chk({tag, ".valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".csr_valid"}, 32'(o_csr_valid), 32'd0);
    chk({tag, ".csr_wen"}, 32'(o_csr_wen), 32'd0);
    chk({tag, ".rd_wen"}, 32'(o_rd_wen), 32'd0);
    chk({tag, ".jump"}, 32'(o_jump), 32'd0);
    chk({tag, ".illegal"}, 32'(o_illegal), 32'd0);
    chk({tag, ".csr_t"}, 32'(o_csr_t), 32'd2);
    chk({tag, ".csr"}, 32'(o_csr), 32'd0);
    chk({tag, ".wdata"}, o_csr_wdata, 32'd0);
    chk({tag, ".csr_pc"}, o_csr_pc, 32'd0);
    chk({tag, ".mcause"}, o_mcause, 32'd0);
    chk({tag, ".rd"}, 32'(o_rd), 32'd0);
    chk({tag, ".rd_data"}, o_rd_data, 32'd0);
    chk({tag, ".npc"}, o_npc, 32'd0);
  endtask

  // One full instruction from IDLE back to IDLE. Called on a falling edge.
  // chk_t[1] enables the READ-cycle o_csr_t check, chk_t[0] the WRITE-cycle one.
  task automatic run_op(input string tag,
                        input logic [2:0] op, input logic imm, input logic [4:0] rs1,
                        input logic [31:0] src, input logic [11:0] csr, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] rdata, input logic [31:0] upc,
                        input logic [1:0] chk_t, input logic [2:0] t_rd, input logic [2:0] t_wr,
                        input logic exp_wen, input logic [31:0] exp_wdata,
                        input logic exp_rd_wen, input logic [31:0] exp_rd_data,
                        input logic exp_jump, input logic [31:0] exp_npc,
                        input logic exp_illegal, input int stall);
    i_op = op; i_imm = imm; i_rs1 = rs1; i_src = src; i_csr = csr; i_rd = rd; i_pc = pc;
    i_csr_rdata = rdata; i_csr_upc = upc;
    i_ready = (stall == 0);
    i_valid = 1'b1;
    chk({tag, ".idle_ready"}, 32'(o_ready), 32'd1);
    @(negedge i_clock);  // READ
    chk({tag, ".rd_ready"}, 32'(o_ready), 32'd0);
    chk({tag, ".rd_valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".rd_csr_valid"}, 32'(o_csr_valid), 32'd0);
    chk({tag, ".rd_csr_wen"}, 32'(o_csr_wen), 32'd0);
    chk({tag, ".rd_csr"}, 32'(o_csr), 32'(csr));
    if (chk_t[1]) chk({tag, ".rd_csr_t"}, 32'(o_csr_t), 32'(t_rd));
    @(negedge i_clock);  // WRITE
    chk({tag, ".wr_valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".wr_csr_valid"}, 32'(o_csr_valid), 32'(exp_wen));
    chk({tag, ".wr_csr_wen"}, 32'(o_csr_wen), 32'(exp_wen));
    if (chk_t[0]) chk({tag, ".wr_csr_t"}, 32'(o_csr_t), 32'(t_wr));
    if (exp_wen && op <= 3'd2) chk({tag, ".wr_wdata"}, o_csr_wdata, exp_wdata);
    if (op == 3'd3) begin
      chk({tag, ".wr_pc"}, o_csr_pc, pc);
      chk({tag, ".wr_mcause"}, o_mcause, 32'd11);
    end
    @(negedge i_clock);  // RESP
    chk({tag, ".rs_valid"}, 32'(o_valid), 32'd1);
    chk({tag, ".rs_ready"}, 32'(o_ready), 32'd0);
    chk({tag, ".rs_csr_valid"}, 32'(o_csr_valid), 32'd0);
    chk({tag, ".rs_rd"}, 32'(o_rd), 32'(rd));
    chk({tag, ".rs_rd_wen"}, 32'(o_rd_wen), 32'(exp_rd_wen));
    if (op <= 3'd4) chk({tag, ".rs_rd_data"}, o_rd_data, exp_rd_data);
    chk({tag, ".rs_jump"}, 32'(o_jump), 32'(exp_jump));
    if (exp_jump) chk({tag, ".rs_npc"}, o_npc, exp_npc);
    chk({tag, ".rs_illegal"}, 32'(o_illegal), 32'(exp_illegal));
    for (int k = 0; k < stall; k++) begin
      i_csr_rdata = ~rdata;
      i_csr_upc = ~upc;
      @(negedge i_clock);
      chk({tag, ".stall_valid"}, 32'(o_valid), 32'd1);
      chk({tag, ".stall_ready"}, 32'(o_ready), 32'd0);
      chk({tag, ".stall_rd_wen"}, 32'(o_rd_wen), 32'(exp_rd_wen));
      chk({tag, ".stall_rd_data"}, o_rd_data, exp_rd_data);
      chk({tag, ".stall_csr_wen"}, 32'(o_csr_wen), 32'd0);
    end
    i_ready = 1'b1;
    @(negedge i_clock);  // back in IDLE
    i_valid = 1'b0;
    chk({tag, ".done_ready"}, 32'(o_ready), 32'd1);
    chk({tag, ".done_valid"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    // Reset state.
    @(negedge i_clock);
    @(negedge i_clock);
    chk_reset_outputs("reset");
    i_reset = 1'b1;
    @(negedge i_clock);
    chk_reset_outputs("post_reset_idle");

    // csrrw mtvec <- 0x80000100, old 0.
    run_op("csrrw_mtvec", 3'd0, 1'b0, 5'd1, 32'h8000_0100, 12'h305, 5'd5, 32'h0, 32'h0, 32'h0,
           2'b11, 3'b010, 3'b001, 1'b1, 32'h8000_0100, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    // csrrs mstatus |= 0x8.
    run_op("csrrs_mstatus", 3'd1, 1'b0, 5'd3, 32'h8, 12'h300, 5'd5, 32'h0, 32'h1800, 32'h0,
           2'b11, 3'b010, 3'b001, 1'b1, 32'h1808, 1'b1, 32'h1800, 1'b0, 32'h0, 1'b0, 0);
    // csrrs with rs1 = 0 is a pure read.
    run_op("csrrs_rs1_zero", 3'd1, 1'b0, 5'd0, 32'h8, 12'h300, 5'd5, 32'h0, 32'h1800, 32'h0,
           2'b11, 3'b010, 3'b001, 1'b0, 32'h0, 1'b1, 32'h1800, 1'b0, 32'h0, 1'b0, 0);
    // csrrci with zimm 8 clears bit 3; rd = 0 means no register write.
    run_op("csrrci_zimm", 3'd2, 1'b1, 5'd8, 32'hFFFF_FFFF, 12'h300, 5'd0, 32'h0, 32'h1888, 32'h0,
           2'b11, 3'b010, 3'b001, 1'b1, 32'h1880, 1'b0, 32'h1888, 1'b0, 32'h0, 1'b0, 0);
    // ecall redirects to mtvec and writes mepc/mcause.
    run_op("ecall", 3'd3, 1'b0, 5'd0, 32'h0, 12'h000, 5'd0, 32'h8000_0040, 32'h0, 32'h8000_0100,
           2'b11, 3'b011, 3'b011, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b0, 0);
    // mret redirects to mepc without a write.
    run_op("mret", 3'd4, 1'b0, 5'd0, 32'h0, 12'h000, 5'd0, 32'h0, 32'h0, 32'h8000_0040,
           2'b10, 3'b000, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_0040, 1'b0, 0);
    // csrrw to read-only mvendorid is illegal but still returns the old value.
    run_op("csrrw_ro", 3'd0, 1'b0, 5'd2, 32'h1234, 12'hF11, 5'd5, 32'h0, 32'h7973_7978, 32'h0,
           2'b11, 3'b010, 3'b001, 1'b0, 32'h0, 1'b0, 32'h7973_7978, 1'b0, 32'h0, 1'b1, 0);
    // Reserved op 111.
    run_op("op_111", 3'd7, 1'b0, 5'd1, 32'h1, 12'h300, 5'd5, 32'h0, 32'h1800, 32'h0,
           2'b00, 3'b000, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0);
    // Response held for 5 cycles with i_ready low while read data changes.
    run_op("stall", 3'd0, 1'b0, 5'd4, 32'hDEAD_BEEF, 12'h340, 5'd7, 32'h0, 32'h55AA_55AA, 32'h0,
           2'b11, 3'b010, 3'b001, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h55AA_55AA, 1'b0, 32'h0, 1'b0, 5);

    // Reset asserted during WRITE: strobe masked at once, outputs cleared next cycle.
    i_op = 3'd0; i_imm = 1'b0; i_rs1 = 5'd1; i_src = 32'hCAFE_0001; i_csr = 12'h305;
    i_rd = 5'd5; i_pc = 32'h8000_0080; i_csr_rdata = 32'h1111_2222; i_csr_upc = 32'h3333_4444;
    i_valid = 1'b1;
    @(negedge i_clock);  // READ
    @(negedge i_clock);  // WRITE
    chk("rst_wr.pre_csr_valid", 32'(o_csr_valid), 32'd1);
    i_reset = 1'b0;
    #1;
    chk("rst_wr.gated_csr_valid", 32'(o_csr_valid), 32'd0);
    chk("rst_wr.gated_csr_wen", 32'(o_csr_wen), 32'd0);
    i_valid = 1'b0;
    @(negedge i_clock);
    chk_reset_outputs("rst_wr");
    i_reset = 1'b1;
    @(negedge i_clock);
    chk("rst_wr.idle_ready", 32'(o_ready), 32'd1);
    chk("rst_wr.idle_valid", 32'(o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
